// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional macro IFETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, inflight, discard;
    logic [31:0]     fetch_pc, rsp_pc;
    logic [31:0]     redir_pc;
    logic            misalign_q;

    logic [CW:0]     used;
    logic            req_fire, rsp_fire, rsp_keep, pop;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_pc = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (redirect_valid)
            misalign_q <= |redirect_pc[1:0];
    end
`else
    assign redir_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign misalign_q = 1'b0;
`endif

    assign fetch_misalign = misalign_q;

    // Outstanding requests and buffered entries share one credit pool.
    assign used           = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = (used < DEPTH_W) && !redirect_valid && !misalign_q;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire = imem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_fire && (discard == '0) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? fifo_mem[rd_ptr].data : '0;
    assign instr_pc    = instr_valid ? fifo_mem[rd_ptr].pc   : '0;

    // NOTE: the FIFO storage has no reset; every read of it is gated by instr_valid,
    // so stale contents never reach the outputs and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (rsp_keep)
            fifo_mem[wr_ptr] <= '{pc: rsp_pc, data: imem_rsp_data};
    end

    // NOTE: all state below uses non-blocking assignments so every update sees
    // the pre-edge values, matching how the combinational handshakes were computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's response must be dropped.
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - CW'(rsp_fire);
            discard  <= inflight - CW'(rsp_fire);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (discard != '0))
                discard <= discard - CW'(1);
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end
endmodule
